load_store_unit: RTL
====================

Name: load_store_unit

Overview:
Memory-side initiator that drives Data_Memory's Mem_Addr/Write_Data/MemRead/MemWrite/Read_Data interface on behalf of the datapath. Accepts one load/store request at a time over a valid/ready handshake. Handles byte/half/word/double accesses, little-endian. Loads are sign- or zero-extended. Sub-doubleword stores use read-modify-write.

Parameters:
READ_LATENCY, 1, cycles MemRead and Mem_Addr are held before Read_Data is captured (1..4)
XLEN, 64, data/address width

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request
req_write  input  1  1=store, 0=load
req_size  input  2  00 byte, 01 half, 10 word, 11 double
req_unsigned  input  1  load zero-extend when 1
req_addr  input  XLEN  byte address
req_wdata  input  XLEN  store data, right-justified
resp_valid  output  1  one-cycle completion pulse
resp_err  output  1  misaligned access, valid with resp_valid
resp_rdata  output  XLEN  extended load data, valid with resp_valid
Mem_Addr  output  XLEN  doubleword-aligned address (bits[2:0]=0)
Write_Data  output  XLEN  full doubleword to memory
MemRead  output  1  memory read enable
MemWrite  output  1  memory write enable, commits on clk edge
Read_Data  input  XLEN  memory read doubleword

Behaviour:
- Reset (reset=0 at an edge): state IDLE. All outputs 0: req_ready, resp_valid, resp_err, resp_rdata, Mem_Addr, Write_Data, MemRead, MemWrite. An in-flight op is abandoned and no later MemWrite is issued for it.
- States: IDLE, RD, WR, RESP.
- IDLE: req_ready=1 (0 in every other state and while in reset). On req_valid&req_ready, register addr/size/write/unsigned/wdata. Mem_Addr is set to {addr[63:3],3'b000}.
- Misalignment: addr mod (1<<size) != 0 -> go to RESP with resp_err=1, resp_rdata=0. MemRead and MemWrite stay 0.
- Aligned load -> RD.
- Aligned double store -> WR with Write_Data=wdata.
- Aligned partial store -> RD.
- RD: MemRead=1 for READ_LATENCY cycles with Mem_Addr stable. Read_Data is captured at the last RD edge. A load then goes to RESP. A store merges into the captured doubleword and goes to WR.
- Merge: bytes [off, off+(1<<size)-1] of the captured word are replaced with the low bytes of wdata, where off=addr[2:0].
- WR: MemWrite=1 for exactly 1 cycle with Write_Data/Mem_Addr stable, then RESP.
- RESP: resp_valid=1 for 1 cycle, then IDLE. For a load, resp_rdata = captured>>(8*off), truncated to the size, then sign/zero-extended to 64. For a store, resp_rdata=0.
- Latency in cycles after the accept edge, with READ_LATENCY=1: load resp at +2; double store resp at +2; partial store resp at +3; misaligned resp at +1. Each READ_LATENCY above 1 adds 1 to any path through RD.
- req_unsigned is ignored for stores and for double loads.
- Requests presented while req_ready=0 are not accepted. The requester holds them.
- MemRead and MemWrite are never high in the same cycle.
- Back-to-back: a new request may be accepted in the cycle after RESP.

Test Plan:
- Memory[0x08]=0x8877665544332211. Load byte, signed, addr 0x0F -> resp_rdata=0xFFFFFFFFFFFFFF88 at accept+2, Mem_Addr=0x08, MemRead high 1 cycle. Same request with unsigned -> 0x0000000000000088.
- Same memory. Store half 0xBEEF at addr 0x0A -> RD then WR; Write_Data=0x88776655BEEF2211; resp at accept+3. A following load double at 0x08 returns 0x88776655BEEF2211.
- Store double 0x00000000000BE2EA at addr 0x10 -> single MemWrite cycle at accept+1, no MemRead, resp at accept+2. Load word signed at 0x10 -> 0x00000000000BE2EA.
- Load word at 0x0A -> resp_err=1 at accept+1, resp_rdata=0, MemRead and MemWrite never asserted.
- Partial store to 0x08: drive reset=0 during RD -> outputs all 0 next cycle, MemWrite never asserts, memory[0x08] unchanged. After release, req_ready=1.
- READ_LATENCY=3: load double at 0x08 -> MemRead high 3 cycles, resp at accept+4. Hold req_valid during busy -> exactly one accept per transaction.

Source files
------------

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Memory-side initiator between the datapath and Data_Memory.
//            Takes one load/store request at a time over a valid/ready
//            handshake. Supports byte/half/word/double little-endian
//            accesses. Loads are sign- or zero-extended. Sub-doubleword
//            stores are done as read-modify-write of the containing
//            doubleword.
// Ports    : clk, reset (sync, active-low)
//            req_valid/req_ready handshake; req_write, req_size,
//            req_unsigned, req_addr, req_wdata request fields
//            resp_valid (1-cycle pulse), resp_err, resp_rdata
//            Mem_Addr, Write_Data, MemRead, MemWrite -> memory
//            Read_Data <- memory
// Revision : 1.0  initial release
// ============================================================================
module load_store_unit #(
  parameter int READ_LATENCY = 1,
  parameter int XLEN         = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic            resp_err,
  output logic [XLEN-1:0] resp_rdata,
  output logic [XLEN-1:0] Mem_Addr,
  output logic [XLEN-1:0] Write_Data,
  output logic            MemRead,
  output logic            MemWrite,
  input  logic [XLEN-1:0] Read_Data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  // Index of the RD cycle at whose closing edge Read_Data is captured.
  localparam logic [2:0] RD_LAST = 3'(READ_LATENCY - 1);

  state_t          state_q,      state_d;
  logic [2:0]      cnt_q,        cnt_d;
  logic [1:0]      size_q,       size_d;
  logic            write_q,      write_d;
  logic            unsigned_q,   unsigned_d;
  logic            err_q,        err_d;
  logic [2:0]      off_q,        off_d;
  logic [XLEN-1:0] wdata_q,      wdata_d;
  logic [XLEN-1:0] mem_addr_q,   mem_addr_d;
  logic [XLEN-1:0] write_data_q, write_data_d;
  logic [XLEN-1:0] rdata_q,      rdata_d;

  logic            req_misaligned;
  logic [XLEN-1:0] lane_mask;
  logic [5:0]      shamt;
  logic [XLEN-1:0] merged;
  logic [XLEN-1:0] rd_shift;
  logic [XLEN-1:0] load_ext;

  // Outputs decode directly from state so they drop together on reset.
  assign req_ready  = (state_q == IDLE) && reset;
  assign MemRead    = (state_q == RD);
  assign MemWrite   = (state_q == WR);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = rdata_q;
  assign Mem_Addr   = mem_addr_q;
  assign Write_Data = write_data_q;

  always_comb begin
    case (req_size)
      2'd0:    req_misaligned = 1'b0;
      2'd1:    req_misaligned = req_addr[0];
      2'd2:    req_misaligned = |req_addr[1:0];
      default: req_misaligned = |req_addr[2:0];
    endcase
  end

  // Byte-lane datapath: merge for partial stores, extract/extend for loads.
  always_comb begin
    case (size_q)
      2'd0:    lane_mask = XLEN'(8'hFF);
      2'd1:    lane_mask = XLEN'(16'hFFFF);
      2'd2:    lane_mask = XLEN'(32'hFFFF_FFFF);
      default: lane_mask = '1;
    endcase
    shamt    = {off_q, 3'b000};
    merged   = (Read_Data & ~(lane_mask << shamt)) | ((wdata_q & lane_mask) << shamt);
    rd_shift = Read_Data >> shamt;
    case (size_q)
      2'd0:    load_ext = unsigned_q ? XLEN'(rd_shift[7:0])
                                     : {{(XLEN-8){rd_shift[7]}}, rd_shift[7:0]};
      2'd1:    load_ext = unsigned_q ? XLEN'(rd_shift[15:0])
                                     : {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
      2'd2:    load_ext = unsigned_q ? XLEN'(rd_shift[31:0])
                                     : {{(XLEN-32){rd_shift[31]}}, rd_shift[31:0]};
      default: load_ext = rd_shift;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    size_d       = size_q;
    write_d      = write_q;
    unsigned_d   = unsigned_q;
    err_d        = err_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    write_data_d = write_data_q;
    // resp_rdata is only non-zero during the RESP cycle.
    rdata_d      = '0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          size_d     = req_size;
          write_d    = req_write;
          unsigned_d = req_unsigned;
          off_d      = req_addr[2:0];
          wdata_d    = req_wdata;
          mem_addr_d = {req_addr[XLEN-1:3], 3'b000};
          err_d      = req_misaligned;
          cnt_d      = '0;
          if (req_misaligned) begin
            state_d = RESP;
          end else if (req_write && (req_size == 2'd3)) begin
            write_data_d = req_wdata;
            state_d      = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        if (cnt_q == RD_LAST) begin
          if (write_q) begin
            write_data_d = merged;
            state_d      = WR;
          end else begin
            rdata_d = load_ext;
            state_d = RESP;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      WR: begin
        state_d = RESP;
      end
      RESP: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      size_q       <= '0;
      write_q      <= 1'b0;
      unsigned_q   <= 1'b0;
      err_q        <= 1'b0;
      off_q        <= '0;
      wdata_q      <= '0;
      mem_addr_q   <= '0;
      write_data_q <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      size_q       <= size_d;
      write_q      <= write_d;
      unsigned_q   <= unsigned_d;
      err_q        <= err_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      mem_addr_q   <= mem_addr_d;
      write_data_q <= write_data_d;
      rdata_q      <= rdata_d;
    end
  end

endmodule
`default_nettype wire
